adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 18 +
 rtl/adder_arbiter_cla.sv | 75 +++++++
 rtl/adder_arbiter_rr_arbiter.sv | 40 ++++
 rtl/adder_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared defaults, id width derivation and op encodings for adder_arbiter
package adder_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int NUM_REQ_DEF    = 4;

    // req_sub encoding: 0 adds, 1 subtracts
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Requester index width; a single requester still gets a 1-bit id
    function automatic int id_width(input int num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/adder_arbiter_cla.sv
// rtl/adder_arbiter_cla.sv - carry-lookahead adder with optional operand inversion
//
// Ports:
//   a, b  operands
//   inv   inverts b and is used as carry-in, so inv=1 yields a - b
//   sum   a + (b ^ inv) + inv, modulo 2^WIDTH
//   cout  carry out of the top bit
module cla_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             inv,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int GRP = 4;
    localparam int NG  = (WIDTH + GRP - 1) / GRP;

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    pp;
    logic [NG:0]      gc;

    assign bb = b ^ {WIDTH{inv}};
    assign g  = a & bb;
    assign p  = a ^ bb;

    always_comb begin
        gg = '0;
        pp = '0;
        gc = '0;
        c  = '0;

        // Group generate/propagate over 4-bit blocks
        for (int j = 0; j < NG; j++) begin
            pp[j] = 1'b1;
            for (int k = 0; k < GRP; k++) begin
                if (j * GRP + k < WIDTH) begin
                    gg[j] = g[j*GRP+k] | (p[j*GRP+k] & gg[j]);
                    pp[j] = pp[j] & p[j*GRP+k];
                end
            end
        end

        // Carries at block boundaries come from the lookahead level only
        gc[0] = inv;
        for (int j = 0; j < NG; j++) begin
            gc[j+1] = gg[j] | (pp[j] & gc[j]);
        end

        // Inside a block the carries start from the block carry-in; the
        // block's top carry is taken from the lookahead level
        for (int j = 0; j < NG; j++) begin
            c[j*GRP] = gc[j];
            for (int k = 0; k < GRP; k++) begin
                if (j * GRP + k < WIDTH) begin
                    if (k == GRP - 1 || j * GRP + k == WIDTH - 1) begin
                        c[j*GRP+k+1] = gc[j+1];
                    end else begin
                        c[j*GRP+k+1] = g[j*GRP+k] | (p[j*GRP+k] & c[j*GRP+k]);
                    end
                end
            end
        end
    end

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// rtl/adder_arbiter_rr_arbiter.sv - round-robin grant from a request vector and the last granted index
//
// Ports:
//   req         request vector, one bit per requester
//   last_grant  index granted most recently; search starts one past it
//   grant       one-hot grant (all zero when no request)
//   grant_id    index of the granted requester
//   any         at least one request present
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    int idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        // Offsets 1..NUM_REQ visit every index once, ending on last_grant itself
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - shares one carry-lookahead adder among NUM_REQ requesters with a single-entry result register
//
// Optional feature macro: ADDER_ARBITER_FLAGS_EN adds registered rsp_cout/rsp_of.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready one-hot or zero)
//   req_lhs/req_rhs      packed operands, requester i in slice i
//   req_sub              per-requester op: 1 subtract, 0 add
//   rsp_valid/rsp_ready  result handshake
//   rsp_id, rsp_res      owning requester and result
//   rsp_cout, rsp_of     carry-out and signed overflow (flags build only)
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_lhs,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rhs,
    input  logic [NUM_REQ-1:0]            req_sub,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
`ifdef ADDER_ARBITER_FLAGS_EN
    output logic                          rsp_cout,
    output logic                          rsp_of,
`endif
    output logic [DATA_WIDTH-1:0]         rsp_res
);

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       last_grant;
    logic                  any_req;
    logic                  issue_ok;
    logic                  issue;
    logic [DATA_WIDTH-1:0] lhs_sel;
    logic [DATA_WIDTH-1:0] rhs_sel;
    logic [DATA_WIDTH-1:0] sum;
    logic                  add_cout;
    logic                  sub;
    op_e                   op;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id),
        .any        (any_req)
    );

    // The result register can take a new op when empty or draining this cycle
    assign issue_ok  = !rst && (!rsp_valid || rsp_ready);
    assign req_ready = issue_ok ? grant : '0;
    assign issue     = issue_ok && any_req;

    assign lhs_sel = req_lhs[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign rhs_sel = req_rhs[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign op      = op_e'(req_sub[grant_id]);
    assign sub     = (op == OP_SUB);

    cla_adder #(
        .WIDTH (DATA_WIDTH)
    ) u_add (
        .a    (lhs_sel),
        .b    (rhs_sel),
        .inv  (sub),
        .sum  (sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_res    <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (issue) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_id;
            rsp_res    <= sum;
            last_grant <= grant_id;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef ADDER_ARBITER_FLAGS_EN
    logic [DATA_WIDTH-1:0] rhs_eff;
    logic                  of_calc;

    // Overflow judged on the operand actually presented to the adder
    assign rhs_eff = rhs_sel ^ {DATA_WIDTH{sub}};
    assign of_calc = (lhs_sel[DATA_WIDTH-1] == rhs_eff[DATA_WIDTH-1]) &&
                     (sum[DATA_WIDTH-1] != lhs_sel[DATA_WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_cout <= 1'b0;
            rsp_of   <= 1'b0;
        end else if (issue) begin
            rsp_cout <= add_cout;
            rsp_of   <= of_calc;
        end
    end
`else
    logic unused_cout;
    assign unused_cout = add_cout;
`endif

endmodule
